uart_rx_fifo: RTL and testbench

Byte FIFO between the UART receiver and the peripherals register block: it captures every byte the receiver reports and holds it until the CPU reads it through the peripherals read port. It removes the single-byte receive hazard, where a second byte arriving before the CPU polls overwrites the first. It provides count, empty, full and sticky-overflow status for the UART status register, and runs entirely in the raw_clk domain.

---
 rtl/uart_rx_fifo_if.sv | 27 ++
 rtl/uart_rx_fifo.sv | 87 ++++++++
 tb/tb_uart_rx_fifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO bus between the UART receiver/peripherals block (master) and uart_rx_fifo (slave).
// Carries the push source, the pop/clear strobes and the status/data returned by the FIFO.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          pop;
    logic          clear;
    logic [7:0]    data_out;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;

    modport master (
        output rx_data, rx_ready, pop, clear,
        input  data_out, count, empty, full, overflow
    );

    modport slave (
        input  rx_data, rx_ready, pop, clear,
        output data_out, count, empty, full, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO capturing UART receiver bytes (rising edge of rx_ready) until the CPU pops them.
// Optional macro UART_RX_FIFO_OVERWRITE_EN: a push into a full FIFO replaces the oldest byte.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input logic           raw_clk,
    input logic           reset,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef UART_RX_FIFO_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          rx_ready_q;

    logic push;
    logic is_empty;
    logic is_full;
    logic full_push;
    logic wr_en;
    logic rd_en;
    logic mem_we;

    always_comb begin
        push      = bus.rx_ready & ~rx_ready_q;
        is_empty  = (count_q == '0);
        is_full   = (count_q == CW'(DEPTH));
        // A push into a full FIFO with no simultaneous pop is the overflow case.
        full_push = push & is_full & ~bus.pop;
        wr_en     = push & ~full_push;
        rd_en     = bus.pop & ~is_empty;
        mem_we    = ~bus.clear & (wr_en | (full_push & OVERWRITE));
    end

    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rx_ready_q <= 1'b1;
        end else begin
            rx_ready_q <= bus.rx_ready;
            if (bus.clear) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else if (full_push) begin
                overflow_q <= 1'b1;
                if (OVERWRITE) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (rd_en) rd_ptr <= rd_ptr + AW'(1);
                if (wr_en && !rd_en)
                    count_q <= count_q + CW'(1);
                else if (!wr_en && rd_en)
                    count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge raw_clk) begin
        if (mem_we)
            mem[wr_ptr] <= bus.rx_data;
    end

    assign bus.data_out = is_empty ? 8'h00 : mem[rd_ptr];
    assign bus.count    = count_q;
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic raw_clk = 1'b0;
    logic reset   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    bit   cmp_en  = 1'b0;

    // Reference model state
    logic [7:0] q[$];
    bit         m_ovf  = 1'b0;
    bit         m_rdyq = 1'b1;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .raw_clk (raw_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 raw_clk = ~raw_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_rdyq = 1'b1;
    endtask

    task automatic model_update(input logic rdy, input logic [7:0] d, input logic p, input logic c);
        bit push;
        push   = rdy && !m_rdyq;
        m_rdyq = rdy;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
        end else if (push && q.size() == DEPTH && !p) begin
            m_ovf = 1'b1;
            if (OVW) begin
                void'(q.pop_front());
                q.push_back(d);
            end
        end else begin
            if (p && q.size() > 0) void'(q.pop_front());
            if (push) q.push_back(d);
        end
    endtask

    // Compare process: outputs settle after the rising edge, checked on the falling edge.
    always @(negedge raw_clk) begin
        if (cmp_en) begin
            chk("cyc_data_out", 32'(bus.data_out), (q.size() > 0) ? 32'(q[0]) : 32'h0);
            chk("cyc_count",    32'(bus.count),    32'(q.size()));
            chk("cyc_empty",    32'(bus.empty),    32'(q.size() == 0));
            chk("cyc_full",     32'(bus.full),     32'(q.size() == DEPTH));
            chk("cyc_overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic rdy, input logic [7:0] d, input logic p, input logic c);
        bus.rx_ready = rdy;
        bus.rx_data  = d;
        bus.pop      = p;
        bus.clear    = c;
        @(posedge raw_clk);
        model_update(rdy, d, p, c);
        @(negedge raw_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        step(1'b0, d, 1'b0, 1'b0);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop_once();
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_ready = 1'b1;
        bus.rx_data  = 8'h00;
        bus.pop      = 1'b0;
        bus.clear    = 1'b0;
        model_reset();
        cmp_en = 1'b1;
        repeat (2) @(negedge raw_clk);
        #1;
        chk("rst_count",    32'(bus.count), 32'd0);
        chk("rst_empty",    32'(bus.empty), 32'd1);
        chk("rst_data_out", 32'(bus.data_out), 32'h00);
        reset = 1'b1;

        // rx_ready already high at reset release: no push
        repeat (3) step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("hold_high_count", 32'(bus.count), 32'd0);
        chk("hold_high_empty", 32'(bus.empty), 32'd1);

        // Push three, pop three
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        chk("abc_count", 32'(bus.count), 32'd3);
        chk("abc_head",  32'(bus.data_out), 32'h41);
        pop_once();
        chk("abc_pop1_data", 32'(bus.data_out), 32'h42);
        chk("abc_pop1_cnt",  32'(bus.count), 32'd2);
        pop_once();
        chk("abc_pop2_data", 32'(bus.data_out), 32'h43);
        chk("abc_pop2_cnt",  32'(bus.count), 32'd1);
        pop_once();
        chk("abc_pop3_data", 32'(bus.data_out), 32'h00);
        chk("abc_pop3_empty", 32'(bus.empty), 32'd1);

        // Overflow with 17 pushes
        for (int i = 0; i <= 16; i++) push_byte(8'(i));
        chk("ovf_full", 32'(bus.full), 32'd1);
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_head", 32'(bus.data_out), OVW ? 32'h01 : 32'h00);
        repeat (15) pop_once();
        chk("ovf_last", 32'(bus.data_out), OVW ? 32'h10 : 32'h0F);
        pop_once();
        chk("ovf_drained", 32'(bus.empty), 32'd1);

        // Full FIFO, push and pop together
        do_clear();
        for (int i = 0; i < DEPTH; i++) push_byte(8'h20 + 8'(i));
        step(1'b0, 8'h99, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0);
        chk("fullpp_count", 32'(bus.count), 32'd16);
        chk("fullpp_ovf",   32'(bus.overflow), 32'd0);
        repeat (15) pop_once();
        chk("fullpp_last", 32'(bus.data_out), 32'h99);
        pop_once();

        // Empty FIFO, push and pop together
        step(1'b0, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("emptypp_count", 32'(bus.count), 32'd1);
        chk("emptypp_data",  32'(bus.data_out), 32'h55);
        pop_once();
        pop_once();
        chk("empty_pop_count", 32'(bus.count), 32'd0);

        // Clear beats a simultaneous push
        for (int i = 0; i <= DEPTH; i++) push_byte(8'h60 + 8'(i));
        repeat (11) pop_once();
        chk("pre_clear_count", 32'(bus.count), 32'd5);
        chk("pre_clear_ovf",   32'(bus.overflow), 32'd1);
        step(1'b0, 8'h77, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        chk("clear_count", 32'(bus.count), 32'd0);
        chk("clear_empty", 32'(bus.empty), 32'd1);
        chk("clear_ovf",   32'(bus.overflow), 32'd0);
        push_byte(8'h12);
        chk("post_clear_data", 32'(bus.data_out), 32'h12);

        // Asynchronous reset mid-operation
        push_byte(8'h34);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_count", 32'(bus.count), 32'd0);
        chk("async_rst_data",  32'(bus.data_out), 32'h00);
        chk("async_rst_ovf",   32'(bus.overflow), 32'd0);
        @(negedge raw_clk);
        #1;
        reset = 1'b1;

        // Randomized traffic: pop-light phase fills and overflows, pop-heavy phase drains
        for (int n = 0; n < 2400; n++) begin
            logic rdy, p, c;
            rdy = 1'($urandom_range(0, 1));
            p   = (n < 1200) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
            c   = ($urandom_range(0, 79) == 0);
            step(rdy, 8'($urandom), p, c);
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
